uart_rx_param: RTL



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_param_if.sv | 26 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter.
// Contents: parity-mode constants, receiver FSM state encoding and a
// constant-friendly ceil(log2) helper used to size counters.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, character/status strobes out.
// Modports:
//   slave  - the receiver (reads rxd, drives all status outputs)
//   master - the consumer / line driver (drives rxd, reads status)
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_break;
  logic                 rx_idle;
  logic                 rx_eop;

  modport slave (
    input  rxd,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_idle, rx_eop
  );

  modport master (
    output rxd,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_idle, rx_eop
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator (phase accumulator).
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   tick       - one-cycle strobe at BAUD*OVERSAMPLE Hz on average
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned Inc = BAUD * OVERSAMPLE;

  if (CLK_FREQ < Inc) begin : g_bad_clk
    $error("uart_baud_tick: CLK_FREQ must be >= BAUD*OVERSAMPLE");
  end

  logic [31:0] acc_q, acc_d, sum;
  logic        tick_d;

  // Carry out of the accumulator marks a tick; remainder keeps long-term rate exact.
  always_comb begin
    sum = acc_q + Inc;
    if (sum >= CLK_FREQ) begin
      acc_d  = sum - CLK_FREQ;
      tick_d = 1'b1;
    end else begin
      acc_d  = sum;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      tick  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      tick  <= tick_d;
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: N data bits, optional parity, 1/2 stop bits,
// false-start rejection, framing/parity flags and packet-gap detection.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   bus        - uart_rx_param_if.slave (rxd in; data/strobes/status out)
// Optional feature macro: UART_RX_BREAK_DETECT_EN (all-zero frame with low
// first stop bit reports rx_break instead of rx_valid).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 2
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_param_if.slave bus
);
  localparam int unsigned CntW   = clog2(OVERSAMPLE);
  localparam int unsigned GapMax = GAP_BITS * OVERSAMPLE;
  localparam int unsigned GapW   = clog2(GapMax + 1);
  localparam logic [CntW-1:0] MidCnt   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [GapW-1:0] GapSat   = GapW'(GapMax);
  localparam logic [GapW-1:0] GapPre   = GapW'(GapMax - 1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be a power of 2 and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
    $error("uart_rx_param: GAP_BITS must be 1..15");
  end

  logic tick;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Input path: 2-FF synchroniser, then 3-sample majority on ticks.
  logic       sync1, sync2, rxb;
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 2'b11;
      rxb   <= 1'b1;
    end else begin
      sync1 <= bus.rxd;
      sync2 <= sync1;
      if (tick) begin
        hist <= {hist[0], sync2};
        rxb  <= (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
      end
    end
  end

  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q, rx_data_q;
  logic                 par_bit_q, frame_err_q;
  logic                 rx_valid_q, perr_q, ferr_q, brk_q;
  logic                 par_calc, par_err, frame_now, is_break;

  always_comb begin
    par_calc = ^{shreg_q, par_bit_q};
    par_err  = 1'b0;
    if (PARITY == PAR_ODD) par_err = ~par_calc;
    else if (PARITY == PAR_EVEN) par_err = par_calc;
  end

  assign frame_now = frame_err_q | ~rxb;

`ifdef UART_RX_BREAK_DETECT_EN
  // Only judged on the first stop sample: data, parity and that stop all low.
  assign is_break = (bit_idx_q == 4'd0) && (shreg_q == '0) && !rxb &&
                    ((PARITY == PAR_NONE) || !par_bit_q);
`else
  assign is_break = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      if (tick) begin
        cnt_q <= cnt_q + 1'b1;
        unique case (state_q)
          StIdle: begin
            if (!rxb) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == MidCnt) begin
              bit_idx_q <= '0;
              state_q   <= rxb ? StIdle : StData;
            end
          end
          StData: begin
            if (cnt_q == MidCnt) begin
              shreg_q <= {rxb, shreg_q[DATA_BITS-1:1]};
              if (bit_idx_q == LastData) begin
                bit_idx_q   <= '0;
                frame_err_q <= 1'b0;
                state_q     <= (PARITY != PAR_NONE) ? StParity : StStop;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
          end
          StParity: begin
            if (cnt_q == MidCnt) begin
              par_bit_q <= rxb;
              state_q   <= StStop;
            end
          end
          StStop: begin
            if (cnt_q == MidCnt) begin
              if (is_break) begin
                brk_q     <= 1'b1;
                bit_idx_q <= '0;
                state_q   <= StWaitHigh;
              end else if (bit_idx_q == LastStop) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= shreg_q;
                perr_q     <= par_err;
                ferr_q     <= frame_now;
                bit_idx_q  <= '0;
                state_q    <= rxb ? StIdle : StWaitHigh;
              end else begin
                frame_err_q <= frame_now;
                bit_idx_q   <= bit_idx_q + 1'b1;
              end
            end
          end
          StWaitHigh: begin
            if (rxb) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Gap tracking: rx_eop marks the idle rise that follows at least one character.
  logic [GapW-1:0] gap_q;
  logic            seen_q, eop_q, idle_rise;

  assign idle_rise = tick && (state_q == StIdle) && (gap_q == GapPre);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q  <= GapSat;
      seen_q <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      eop_q <= idle_rise && seen_q;
      if (state_q != StIdle) gap_q <= '0;
      else if (tick && gap_q != GapSat) gap_q <= gap_q + 1'b1;
      if (idle_rise) seen_q <= 1'b0;
      if (rx_valid_q) seen_q <= 1'b1;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_frame_err  = ferr_q;
  // Without break detection is_break is 0, so brk_q stays constant 0.
  assign bus.rx_break      = brk_q;
  assign bus.rx_idle       = (gap_q == GapSat);
  assign bus.rx_eop        = eop_q;
endmodule
